// File: rtl/dmem_responder.sv
// Fixed-latency handshaked data-memory responder for the MEM stage.
// Optional illegal-request flag (both ops set) enabled by defining DMEM_ERR_EN.
module dmem_responder #(
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [31:0]           i_write_data,
    output logic                  o_resp_valid,
    output logic [31:0]           o_read_data,
    output logic                  o_stall
`ifdef DMEM_ERR_EN
    ,
    output logic                  o_err
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } state_t;

`ifdef DMEM_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    localparam logic [3:0] LOAD_COUNT = 4'(LATENCY - 1);

    state_t                r_state;
    state_t                w_nextState;
    logic [3:0]            r_count;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_opRead;
    logic                  r_opWrite;
    logic [31:0]           r_readData;
    logic [31:0]           r_mem [DEPTH];

    logic w_transfer;
    logic w_commit;
    logic w_illegal;
    logic w_doStore;
    logic w_doLoad;

    assign w_transfer = (r_state == IDLE) & i_req_valid & (i_mem_read | i_mem_write);
    assign w_commit   = (r_state == ACCESS) & (r_count == 4'd0);
    // Both ops set is a store unless the error flag is built in, then it is a no-op.
    assign w_illegal  = ERR_EN & r_opRead & r_opWrite;
    assign w_doStore  = w_commit & r_opWrite & ~w_illegal;
    assign w_doLoad   = w_commit & r_opRead & ~r_opWrite;

    assign o_stall     = w_transfer | (r_state == ACCESS);
    assign o_read_data = r_readData;

`ifdef DMEM_ERR_EN
    assign o_err = (r_state == RESPOND) & r_opRead & r_opWrite;
`endif

    always_comb begin
        w_nextState  = r_state;
        o_req_ready  = 1'b0;
        o_resp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (w_transfer) begin
                    w_nextState = ACCESS;
                end
            end
            ACCESS: begin
                if (r_count == 4'd0) begin
                    w_nextState = RESPOND;
                end
            end
            RESPOND: begin
                o_resp_valid = 1'b1;
                w_nextState  = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= IDLE;
            r_count    <= 4'd0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_opRead   <= 1'b0;
            r_opWrite  <= 1'b0;
            r_readData <= 32'd0;
        end else begin
            r_state <= w_nextState;
            if (w_transfer) begin
                r_addr    <= i_address;
                r_wdata   <= i_write_data;
                r_opRead  <= i_mem_read;
                r_opWrite <= i_mem_write;
                r_count   <= LOAD_COUNT;
            end else if ((r_state == ACCESS) && (r_count != 4'd0)) begin
                r_count <= r_count - 4'd1;
            end
            if (w_doLoad) begin
                r_readData <= r_mem[r_addr];
            end
        end
    end

    // Array has no reset; a store is only committed from ACCESS, so reset aborts it.
    always_ff @(posedge i_clk) begin
        if (w_doStore) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder that serves the load/store requests issued by the MEM pipeline stage.
- Replaces the single-cycle data array with a handshaked, fixed-latency memory model.
- Accepts one read or write request at a time, holds the pipeline through `stall` while busy, and returns read data with a one-cycle `resp_valid` pulse.
- Sits between the MEM stage and the MEM/WB register.

Parameters:
- DEPTH, 256, number of 32-bit words in the array; address is a word index.
- ADDR_WIDTH, 8, width of `address`; must equal log2(DEPTH).
- LATENCY, 2, cycles spent in ACCESS per request; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  MEM stage presents a request this cycle.
- req_ready  output  1  responder can accept a request this cycle.
- mem_read  input  1  request is a load.
- mem_write  input  1  request is a store.
- address  input  ADDR_WIDTH  word index, taken from alu_result[7:0].
- write_data  input  32  store data.
- resp_valid  output  1  one-cycle pulse: request complete.
- read_data  output  32  load data; valid while resp_valid=1 for loads.
- stall  output  1  freeze the upstream pipeline registers.
- err  output  1  only with DMEM_ERR_EN; illegal request flag, qualified by resp_valid.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, captured addr/data/op=0, resp_valid=0, read_data=0, err=0.
  - Array contents are not reset.
  - Reset asserted before the commit edge aborts an in-flight store: array is unchanged.
- States: IDLE, ACCESS, RESPOND.
- IDLE:
  - req_ready=1.
  - Transfer occurs only when req_valid=1 and (mem_read|mem_write)=1.
  - req_valid=1 with no op set is ignored; stays in IDLE, no response.
  - On transfer: capture address, write_data and op; load counter=LATENCY-1; go to ACCESS.
- ACCESS:
  - req_ready=0.
  - Counter decrements each cycle.
  - On the cycle counter==0 (commit cycle), the clock edge ending it performs the operation:
    - store: array[addr] <= data;
    - load: read_data <= array[addr];
  - Then go to RESPOND.
  - Resulting occupancy in ACCESS is exactly LATENCY cycles.
- RESPOND:
  - resp_valid=1 for exactly one cycle; req_ready=0.
  - Next state is IDLE.
  - read_data holds its value until the next load commits; a store does not modify read_data.
- Timing:
  - Transfer in cycle 0, ACCESS in cycles 1..LATENCY, resp_valid in cycle LATENCY+1.
  - Next transfer possible in cycle LATENCY+2.
  - Throughput is 1 request per LATENCY+2 cycles.
- stall = (state==IDLE & req_valid & (mem_read|mem_write)) | (state==ACCESS). It is combinational.
  - Low in RESPOND, so the pipeline advances in the same cycle the response is presented.
- Both mem_read and mem_write set (without DMEM_ERR_EN): treated as a store; read_data is unchanged.
- Inputs are sampled only at transfer; changes during ACCESS/RESPOND have no effect.
- Read-after-write to the same address returns the new data; requests are strictly serialised.
- Address is used unmodified. No bounds check is needed because ADDR_WIDTH covers DEPTH.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined:
  - `err` port exists.
  - A request with both mem_read and mem_write set is accepted and goes through ACCESS with no array access and read_data unchanged.
  - In RESPOND it gives resp_valid=1 with err=1.
  - err=0 for legal requests and outside RESPOND.
  - err resets to 0.
- Undefined: no `err` port; the both-ops case behaves as a store (see Behaviour).

Test Plan:
- Reset and idle:
  - Stimulus: reset low mid-ACCESS of a store of 0xDEADBEEF to addr 0x10; then release and load addr 0x10.
  - Required: outputs return to their reset values immediately, and the load returns the pre-reset array value, not 0xDEADBEEF.
- Store then load, LATENCY=2:
  - Stimulus: store 0x12345678 to addr 0x05 in cycle 0.
  - Required: stall=1 in cycles 0-2, resp_valid=1 only in cycle 3.
  - Stimulus: load addr 0x05 in cycle 4.
  - Required: resp_valid=1 in cycle 7 with read_data=0x12345678.
- Back-to-back requests:
  - Stimulus: req_valid held high with a new op every cycle.
  - Required: req_ready=1 only in IDLE cycles (0, 4, 8, ...); exactly one resp_valid per accepted request; no request is lost or duplicated.
- No-op request:
  - Stimulus: req_valid=1 with mem_read=mem_write=0 for 5 cycles.
  - Required: state stays IDLE, stall=0, no resp_valid.
- Address wrap and extremes:
  - Stimulus: store 0xFFFFFFFF to addr 0xFF and 0x00000001 to addr 0x00; then load both.
  - Required: each load returns its own value; no aliasing.
- Both ops set:
  - Stimulus: mem_read=mem_write=1 with write_data=0xA5A5A5A5 to addr 0x20.
  - Required without DMEM_ERR_EN: a later load of addr 0x20 returns 0xA5A5A5A5.
  - Required with DMEM_ERR_EN: err=1 together with resp_valid, a later load returns the old addr 0x20 value, and err=0 on all legal requests.
